// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential unsigned restoring divider.
// Shifts the partial remainder left one bit per clock, pulling in the next
// dividend bit, and subtracts the divisor whenever it fits. After n
// iterations the shift register holds the quotient and the partial
// remainder holds the remainder. A zero divisor is resolved in one cycle
// with a saturated quotient.
module shift_sub_divider #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int cw = $clog2(n) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, next_state;

    logic [n-1:0]  r;
    logic [n-1:0]  qs;
    logic [n-1:0]  d;
    logic [cw-1:0] cnt;

    logic [n:0]    r_shift;
    logic          r_ge_d;
    logic [n-1:0]  r_next;
    logic [n-1:0]  qs_next;
    logic          last_iter;
    logic          accept;

    // One restoring step: the shifted remainder is n+1 bits wide so the
    // comparison cannot overflow; when it fits, the difference is below the
    // divisor and so the low n bits of an n-bit subtraction are exact.
    always_comb begin
        r_shift   = {r, qs[n-1]};
        r_ge_d    = (r_shift >= {1'b0, d});
        r_next    = r_ge_d ? (r_shift[n-1:0] - d) : r_shift[n-1:0];
        qs_next   = {qs[n-2:0], r_ge_d};
        last_iter = (cnt == cw'(n - 1));
        accept    = start && ((state == IDLE) || (state == DONE));
    end

    // State register; reset drops straight back to IDLE even mid-operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status outputs; DONE accepts a new start just like IDLE
    // so back-to-back operations need no idle gap.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    next_state = (divisor == '0) ? DONE : RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: load operands on an accepted start, iterate in RUN, and only
    // write the visible results on the final step so they hold meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r           <= '0;
            qs          <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor != '0) begin
                d   <= divisor;
                r   <= '0;
                qs  <= dividend;
                cnt <= '0;
            end else begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            r   <= r_next;
            qs  <= qs_next;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
                quotient    <= qs_next;
                remainder   <= r_next;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule
